// File: rtl/sd_request_arbiter.sv
// Read/write request arbiter for the SDRAM command sequencer: round-robin clients, periodic refresh first.
// Optional WAIT_DONE watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_request_arbiter #(
    parameter int ADDRESS_SIZE     = 20,
    parameter int DATA_SIZE        = 16,
    parameter int REFRESH_INTERVAL = 780,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_Read_Request,
    input  logic [ADDRESS_SIZE-1:0] i_Read_Address,
    input  logic                    i_Write_Request,
    input  logic [ADDRESS_SIZE-1:0] i_Write_Address,
    input  logic [DATA_SIZE-1:0]    i_Write_Data,
    output logic                    o_Read_Grant,
    output logic                    o_Write_Grant,
    output logic [DATA_SIZE-1:0]    o_Read_Data,
    output logic                    o_Data_Valid,
    output logic                    o_Cmd_Valid,
    output logic                    o_Cmd_Write,
    output logic                    o_Cmd_Refresh,
    output logic [ADDRESS_SIZE-1:0] o_Cmd_Address,
    output logic [DATA_SIZE-1:0]    o_Cmd_Data,
    input  logic                    i_Cmd_Ready,
    input  logic                    i_Cmd_Done,
    input  logic [DATA_SIZE-1:0]    i_Cmd_Read_Data,
    output logic                    o_Refresh_Overrun,
    output logic                    o_Timeout,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int RW = $clog2(REFRESH_INTERVAL);

    state_t          state;
    state_t          state_next;
    logic [RW-1:0]   refresh_count;
    logic            refresh_pending;
    logic            last_served_write;

    logic refresh_wrap;
    logic sel_refresh;
    logic sel_read;
    logic sel_write;
    logic sel_any;
    logic read_done;
    logic refresh_done;
    logic pending_next;
    logic wd_expired;

    assign refresh_wrap = (refresh_count == RW'(REFRESH_INTERVAL - 1));

    // Refresh beats both clients; on a client tie the one not served last wins.
    assign sel_refresh = (state == IDLE) && refresh_pending;
    assign sel_read    = (state == IDLE) && !refresh_pending && i_Read_Request &&
                         (!i_Write_Request || last_served_write);
    assign sel_write   = (state == IDLE) && !refresh_pending && i_Write_Request &&
                         (!i_Read_Request || !last_served_write);
    assign sel_any     = sel_refresh || sel_read || sel_write;

    assign read_done    = (state == WAIT_DONE) && i_Cmd_Done && !o_Cmd_Write && !o_Cmd_Refresh;
    assign refresh_done = (state == WAIT_DONE) && i_Cmd_Done && o_Cmd_Refresh;
    assign pending_next = refresh_wrap || (refresh_pending && !refresh_done);

    // Command channel: a command transfers on the rising edge where o_Cmd_Valid and
    // i_Cmd_Ready are both high; fields stay frozen from selection until that edge.
    assign o_Cmd_Valid = (state == ISSUE);
    assign dbg_state   = state;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_count;

    assign wd_expired = (state == WAIT_DONE) && !i_Cmd_Done &&
                        (wd_count == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || state != WAIT_DONE) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_Timeout <= 1'b0;
        end else begin
            o_Timeout <= wd_expired;
        end
    end
`else
    assign wd_expired = 1'b0;
    // Constant 0; the comparison keeps both builds sharing one parameter list.
    assign o_Timeout  = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (sel_any) state_next = ISSUE;
            ISSUE:     if (i_Cmd_Ready) state_next = WAIT_DONE;
            WAIT_DONE: if (i_Cmd_Done || wd_expired) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            refresh_count     <= '0;
            refresh_pending   <= 1'b0;
            last_served_write <= 1'b1;
            o_Read_Grant      <= 1'b0;
            o_Write_Grant     <= 1'b0;
            o_Read_Data       <= '0;
            o_Data_Valid      <= 1'b0;
            o_Cmd_Write       <= 1'b0;
            o_Cmd_Refresh     <= 1'b0;
            o_Cmd_Address     <= '0;
            o_Cmd_Data        <= '0;
            o_Refresh_Overrun <= 1'b0;
        end else begin
            state             <= state_next;
            refresh_count     <= refresh_wrap ? '0 : refresh_count + RW'(1);
            refresh_pending   <= pending_next;
            o_Refresh_Overrun <= refresh_wrap && refresh_pending;
            o_Read_Grant      <= sel_read;
            o_Write_Grant     <= sel_write;
            o_Data_Valid      <= read_done;
            if (read_done) begin
                o_Read_Data <= i_Cmd_Read_Data;
            end
            if (sel_any) begin
                o_Cmd_Refresh <= sel_refresh;
                o_Cmd_Write   <= sel_write;
                o_Cmd_Address <= sel_read  ? i_Read_Address :
                                 sel_write ? i_Write_Address : '0;
                o_Cmd_Data    <= sel_write ? i_Write_Data : '0;
            end
            if (sel_read) begin
                last_served_write <= 1'b0;
            end else if (sel_write) begin
                last_served_write <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sd_request_arbiter.md
Name: sd_request_arbiter

Overview:
Sits between the read/write client ports and the SDRAM command sequencer. Arbitrates read and write requests with round-robin fairness and injects periodic auto-refresh with top priority. Issues one command at a time over a valid/ready command channel. Returns read data with a one-cycle valid strobe.

Parameters:
ADDRESS_SIZE, 20, width of client and command addresses
DATA_SIZE, 16, width of read/write data
REFRESH_INTERVAL, 780, clock cycles between refresh requests (≥ 8)
TIMEOUT_CYCLES, 255, WAIT_DONE watchdog limit; used only with SD_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
i_Read_Request  in  1  read client request, held until o_Read_Grant
i_Read_Address  in  ADDRESS_SIZE  read address, stable while request high
i_Write_Request  in  1  write client request, held until o_Write_Grant
i_Write_Address  in  ADDRESS_SIZE  write address
i_Write_Data  in  DATA_SIZE  write data
o_Read_Grant  out  1  one-cycle pulse: read request accepted
o_Write_Grant  out  1  one-cycle pulse: write request accepted
o_Read_Data  out  DATA_SIZE  returned read data
o_Data_Valid  out  1  one-cycle pulse: o_Read_Data valid
o_Cmd_Valid  out  1  command present to sequencer
o_Cmd_Write  out  1  1 = write, 0 = read (ignored for refresh)
o_Cmd_Refresh  out  1  command is auto-refresh
o_Cmd_Address  out  ADDRESS_SIZE  latched command address
o_Cmd_Data  out  DATA_SIZE  latched write data
i_Cmd_Ready  in  1  sequencer accepts command on o_Cmd_Valid & i_Cmd_Ready
i_Cmd_Done  in  1  one-cycle pulse: accepted command completed
i_Cmd_Read_Data  in  DATA_SIZE  read data, valid with i_Cmd_Done for reads
o_Refresh_Overrun  out  1  one-cycle pulse: refresh interval expired while refresh already pending
o_Timeout  out  1  one-cycle pulse: watchdog abort (feature only)

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Refresh counter 0, refresh_pending 0.
  - last_served = WRITE, so read wins the first tie.
- Refresh timer:
  - Free-running counter, 0..REFRESH_INTERVAL-1, wraps to 0.
  - On wrap, set refresh_pending (sticky).
  - If refresh_pending is already 1 at wrap, pulse o_Refresh_Overrun; pending stays 1. Refreshes are not queued beyond one.
- IDLE, selection priority:
  - refresh_pending first.
  - Else the single active requester.
  - Else, with both active, the one not equal to last_served.
- IDLE, on selection (same edge):
  - Latch address, data and type into command registers; go to ISSUE.
  - Client grant pulses high for exactly the first ISSUE cycle; no grant for refresh.
  - Update last_served for read/write only.
- Client handshake:
  - Client deasserts its request the cycle after grant.
  - A request still high on the cycle after grant is a new request.
- ISSUE:
  - o_Cmd_Valid = 1, with o_Cmd_Write, o_Cmd_Refresh, o_Cmd_Address and o_Cmd_Data held stable.
  - On o_Cmd_Valid & i_Cmd_Ready: o_Cmd_Valid = 0 next cycle; go to WAIT_DONE.
- WAIT_DONE:
  - Wait for i_Cmd_Done.
  - For a read: register i_Cmd_Read_Data into o_Read_Data and pulse o_Data_Valid the next cycle.
  - For a refresh: clear refresh_pending, unless a wrap occurs on the same cycle, in which case pending stays 1.
  - Return to IDLE. New selection is earliest the cycle after return, so back-to-back commands have one idle cycle.
- Other rules:
  - i_Cmd_Done outside WAIT_DONE is ignored.
  - o_Read_Data holds its last value until the next read completes.
  - Reset mid-operation aborts immediately to reset values. No grant or data pulse is produced for the aborted command.
- Latency, from request sampled in IDLE with ready high:
  - Grant at +1.
  - Cmd accept at +1.
  - Data valid 1 cycle after i_Cmd_Done.

Optional Feature:
SD_ARB_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles in WAIT_DONE.
  - After TIMEOUT_CYCLES cycles without i_Cmd_Done, pulse o_Timeout and return to IDLE.
  - No o_Data_Valid is produced; refresh_pending is left set so the refresh retries.
- Undefined:
  - WAIT_DONE waits indefinitely.
  - o_Timeout is tied to 0 and no counter is built.

Test Plan:
- Single read at addr 0x12345, ready=1, done after 3 cycles with data 0xBEEF -> grant pulse 1 cycle after request; o_Cmd_Address=0x12345, o_Cmd_Write=0; o_Read_Data=0xBEEF with a one-cycle o_Data_Valid.
- Read and write requested together, continuously, for 4 transactions -> grants alternate R,W,R,W; write carries i_Write_Data 0xA5A5 onto o_Cmd_Data.
- REFRESH_INTERVAL=16, write request held -> refresh wins when pending; o_Cmd_Refresh=1; no client grant; pending clears on done.
- i_Cmd_Ready held 0 for 40 cycles with REFRESH_INTERVAL=16 -> command fields stable while valid; o_Refresh_Overrun pulses at the second wrap.
- Reset asserted during WAIT_DONE, then done pulsed -> all outputs 0; done ignored; o_Data_Valid never asserted.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, withhold done -> o_Timeout pulses after 10 cycles; FSM back in IDLE; next request granted.
